// File: rtl/btn_select_ctrl_pkg.sv
// Shared constants and types for the push-button select controller.
// Button indices match the bit positions of sel and btn_db.
package btn_pkg;

  localparam int NUM_BTN = 4;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;

  // 10 ms of stable level at the 100 MHz board clock
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_select_ctrl_if.sv
// Board-side signal bundle: raw buttons in, held select word and feedback out.
interface btn_select_ctrl_if;
  import btn_pkg::*;

  logic     btnC;
  logic     btnU;
  logic     btnL;
  logic     btnR;
  btn_vec_t sel;
  logic     sel_changed;
  btn_vec_t btn_db;

  modport master (
    output btnC, btnU, btnL, btnR,
    input  sel, sel_changed, btn_db
  );

  modport slave (
    input  btnC, btnU, btnL, btnR,
    output sel, sel_changed, btn_db
  );

endinterface

// File: rtl/btn_select_ctrl_debounce_cell.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and a registered one-cycle pulse on each debounced rising edge.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic db_o,
  output logic press_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          db_q,    db_d;
  logic          db_prev_q;
  logic          press_q, press_d;
  logic          level;

  assign level = sync_q[1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = db_q & ~db_prev_q;

    if (level == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = level;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Any return to the accepted level clears the count, so a bouncing contact
  // never accumulates partial credit toward a level change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of the others, which is what lets sync_q behave as a two-stage
      // shift register rather than collapsing into one flop.
      sync_q    <= {sync_q[0], btn_i};
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= press_d;
    end
  end

  assign db_o    = db_q;
  assign press_o = press_q;

endmodule

// File: rtl/btn_select_ctrl.sv
// Turns each clean button press into a toggle of one bit of a held 4-bit mux
// select word; all outputs come straight from flops.
module btn_select_ctrl
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  btn_select_ctrl_if.slave  bus
);

  btn_vec_t btn_raw;
  btn_vec_t btn_db;
  btn_vec_t press;
  btn_vec_t sel_q, sel_d;
  logic     sel_changed_q, sel_changed_d;

  always_comb begin
    btn_raw        = '0;
    btn_raw[BTN_C] = bus.btnC;
    btn_raw[BTN_U] = bus.btnU;
    btn_raw[BTN_L] = bus.btnL;
    btn_raw[BTN_R] = bus.btnR;
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_raw[g]),
      .db_o    (btn_db[g]),
      .press_o (press[g])
    );
  end

  // Simultaneous presses toggle together and share one change pulse.
  always_comb begin
    sel_d         = sel_q ^ press;
    sel_changed_d = |press;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q         <= '0;
      sel_changed_q <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      sel_changed_q <= sel_changed_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.sel_changed = sel_changed_q;
  assign bus.btn_db      = btn_db;

endmodule

// File: doc/btn_select_ctrl.md
# btn_select_ctrl

Debounced select-line generator for the 16:1 switch multiplexer on the board top level. Takes the four raw push-buttons (btnC, btnU, btnL, btnR), synchronises and debounces each one, and turns every clean press into a toggle of one bit of a held 4-bit select word. The select word drives the mux's four select levels in place of the raw buttons, giving stable, latched select values.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000, consecutive stable clocks required to accept a new button level (10 ms at 100 MHz); legal range ≥ 2.
- clk  input  1  system clock (100 MHz board clock).
- rst  input  1  asynchronous, active-high reset.
- btnC  input  1  raw button, asynchronous to clk; toggles sel[0] (mux stage-1 select).
- btnU  input  1  raw button; toggles sel[1] (stage-2 select).
- btnL  input  1  raw button; toggles sel[2] (stage-3 select).
- btnR  input  1  raw button; toggles sel[3] (final-stage select).
- sel  output  4  held select word; sel[3:0] addresses mux input sw[sel].
- sel_changed  output  1  one-cycle pulse in the cycle sel takes a new value.
- btn_db  output  4  debounced button levels {R,L,U,C}, for LED feedback.

## Operation
- Per button, one independent debounce channel: 2-flop synchroniser → debounce counter → debounced level db → rising-edge detect.
- Counter rule, every clock: if sync level == db, cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1, db <= sync level and cnt <= 0. Else cnt <= cnt+1.
- Any glitch back to the db level before the count completes clears cnt; no partial credit.
- Counter width is $clog2(DEBOUNCE_CYCLES); no wrap is possible because the counter clears at the terminal count.
- Press = db rising edge (db_q==0, db==1), registered as a one-cycle press pulse. Releases (falling edges) have no effect on sel.
- On a press pulse for channel i, sel[i] <= ~sel[i] on the next clock.
- Simultaneous press pulses on several channels: all corresponding bits toggle in the same cycle; sel_changed is a single one-cycle pulse.
- A held button gives exactly one toggle, however long it is held.
- Reset (asynchronous, any time, including mid-count): sel=4'b0000, sel_changed=0, btn_db=4'b0000. All synchroniser flops, counters and edge registers clear. A button held through reset release must complete a full debounce before btn_db goes high, and then generates one toggle.

## Timing
- Raw edge to synchronised level: 2 clocks.
- Synchronised change to db change: DEBOUNCE_CYCLES clocks, if the level stays stable.
- db rise to press pulse: 1 clock. Press pulse to sel update and sel_changed high: 1 clock.
- Total latency, clean raw press to new sel: DEBOUNCE_CYCLES + 4 clocks. sel_changed is high in exactly the first cycle the new sel is visible.
- btn_db equals the internal db registers directly, with no extra delay.
- All outputs are registered; the mux sees sel as a clean level with no combinational path from the buttons.

## Structure
- Shared package btn_pkg:
  - NUM_BTN = 4
  - index constants BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3
  - default DEBOUNCE_CYCLES constant
- Sub-module debounce_cell: one synchroniser, counter and db register plus the press-pulse output, parameterised by DEBOUNCE_CYCLES. Instantiated NUM_BTN times via generate.
- The top of btn_select_ctrl holds the sel register, the toggle logic and sel_changed.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert rst mid-simulation with btnC bouncing → sel=0000, sel_changed=0 and btn_db=0000 in the same cycle, before any clk edge.
- Clean press: btnC rises and holds for 20 clocks → sel=0001 exactly 8 clocks after the raw edge, sel_changed high for 1 cycle, no further change while held or on release.
- Bounce: btnU toggles 1,0,1,0 one clock each, then holds 1 → exactly one toggle, sel=0010. A 3-clock high glitch alone (after sync) → no change.
- Simultaneous: btnL and btnR rise on the same cycle → sel goes 0000→1100 in one cycle, single sel_changed pulse.
- Repeat presses: press/release btnC three times, each press longer than 8 clocks → sel[0] sequence 1,0,1, with three sel_changed pulses.
- Reset mid-count: btnR high for 3 clocks of its debounce, then rst pulse, btnR still held → after release of reset, the full 8-clock latency elapses before sel=1000.
